sync_fifo_thr: RTL and testbench

SYNC_FIFO_THR -- requirements
Module: sync_fifo_thr

---
 rtl/sync_fifo_thr.sv | 85 ++++++++
 tb/tb_sync_fifo_thr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: synchronous FIFO with threshold flags,
// sticky error flags and optional first-word-fall-through.
module sync_fifo_thr #(
  parameter int DBITS  = 8,
  parameter int ABITS  = 4,
  parameter int AF_LVL = (1 << ABITS) - 2,
  parameter int AE_LVL = 2,
  parameter bit FWFT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  input  logic             clr_err,
  output logic [DBITS-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ABITS:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] FULL_CNT = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AF_CNT = (ABITS+1)'(AF_LVL);
  localparam logic [ABITS:0] AE_CNT = (ABITS+1)'(AE_LVL);

  logic [DBITS-1:0] mem [DEPTH];
  logic [ABITS-1:0] wptr;
  logic [ABITS-1:0] rptr;
  logic             wr_ok;
  logic             rd_ok;

  // flags come only from the registered count
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // a read frees a slot, so a full FIFO still takes wr+rd
  assign wr_ok = wr && (!full || rd);
  assign rd_ok = rd && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a fresh error wins over a same-cycle clear
      overflow  <= (wr && full && !rd) ||
                   (overflow && !clr_err);
      underflow <= (rd && empty) ||
                   (underflow && !clr_err);
    end
  end

  if (FWFT) begin : g_fwft
    assign dout = empty ? '0 : mem[rptr];
  end else begin : g_reg
    logic [DBITS-1:0] dreg;
    always_ff @(posedge clk) begin
      if (rst)        dreg <= '0;
      else if (rd_ok) dreg <= mem[rptr];
    end
    assign dout = dreg;
  end

endmodule

// File: tb/tb_sync_fifo_thr.sv
// tb_sync_fifo_thr: directed + random checks of sync_fifo_thr
// against a queue-based reference, both read modes.
module tb_sync_fifo_thr;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic       wr, rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty, full, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic       wr2, rd2;
  logic [7:0] din2;
  logic [7:0] dout2;
  logic       empty2, full2, af2, ae2;
  logic [4:0] count2;
  logic       ovf2, unf2;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_unf;
  int         nassert = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  sync_fifo_thr #(.FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din),
    .clr_err(clr_err), .dout(dout), .empty(empty),
    .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_thr #(.FWFT(1'b1)) dut_fw (
    .clk(clk), .rst(rst), .wr(wr2), .rd(rd2), .din(din2),
    .clr_err(clr_err), .dout(dout2), .empty(empty2),
    .full(full2), .almost_full(af2),
    .almost_empty(ae2), .count(count2),
    .overflow(ovf2), .underflow(unf2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // reference: queue holds contents, dout is last word popped
  task automatic step(input logic w, input logic r,
                      input logic c, input logic [7:0] d);
    bit fm, em;
    wr = w; rd = r; clr_err = c; din = d;
    fm = (q.size() == 16);
    em = (q.size() == 0);
    if (r && !em) m_dout = q.pop_front();
    if (w && (!fm || r)) q.push_back(d);
    if (w && fm && !r) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    if (r && em)       m_unf = 1'b1;
    else if (c)        m_unf = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input logic w, input logic r,
                          input logic c);
    rst = 1'b1; wr = w; rd = r; clr_err = c; din = 8'hE7;
    @(posedge clk); #1;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    q.delete();
    m_dout = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    din = 8'h00; wr2 = 1'b0; rd2 = 1'b0; din2 = 8'h00;
    m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0, 1'b0);
    chk("fw_reset_empty", 32'(empty2), 32'd1);
    chk("fw_reset_dout", 32'(dout2), 32'd0);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    step(1'b1, 1'b0, 1'b0, 8'h99);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 10),
           8'($urandom));
    end

    for (int i = 0; i < 40; i++) begin
      if (q.size() != 7)
        step(1'(q.size() < 7), 1'(q.size() > 7),
             1'b0, 8'($urandom));
    end
    chk("count_before_rst", 32'(count), 32'd7);
    do_reset(1'b1, 1'b1, 1'b1);

    wr2 = 1'b1; din2 = 8'h3C;
    @(posedge clk); #1;
    wr2 = 1'b0;
    chk("fw_dout_fall", 32'(dout2), 32'h3C);
    chk("fw_empty_fall", 32'(empty2), 32'd0);
    @(posedge clk); #1;
    chk("fw_dout_hold", 32'(dout2), 32'h3C);
    rd2 = 1'b1;
    @(posedge clk); #1;
    rd2 = 1'b0;
    chk("fw_empty_rd", 32'(empty2), 32'd1);
    chk("fw_dout_rd", 32'(dout2), 32'd0);
    wr2 = 1'b1; din2 = 8'h11;
    @(posedge clk); #1;
    din2 = 8'h22;
    @(posedge clk); #1;
    wr2 = 1'b0;
    chk("fw_count2", 32'(count2), 32'd2);
    chk("fw_head1", 32'(dout2), 32'h11);
    rd2 = 1'b1;
    @(posedge clk); #1;
    chk("fw_head2", 32'(dout2), 32'h22);
    @(posedge clk); #1;
    rd2 = 1'b0;
    chk("fw_drained", 32'(empty2), 32'd1);
    chk("fw_dout_zero", 32'(dout2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
